// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. Takes a word over a valid/ready handshake
// and shifts it out one bit per clock, with a gapless reload on the last bit.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ready_en;
    logic             accept;
    logic             at_last;

    // ready_en keeps load_ready low until one full edge has passed after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            ready_en <= 1'b1;
        end
    end

    assign at_last    = (state == SHIFT) && (cnt == LAST);
    assign load_ready = rst && ready_en && ((state == IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (accept) begin
                        shreg_nxt = din;
                    end else begin
                        shreg_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    // The output end is bit 0 for LSB-first and the top bit for MSB-first
                    if (MSB_FIRST != 0) begin
                        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                    end
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy       = (state == SHIFT);
    assign dout_valid = (state == SHIFT);
    assign dout_last  = at_last;
    assign dout       = (state == SHIFT) ? ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]) : 1'b0;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an LSB-first 4-bit and an MSB-first 8-bit instance checked
// every cycle against a bit-queue model, plus directed literal sequences.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic       lv4, lv8;
    logic [3:0] din4;
    logic [7:0] din8;
    logic       ready4, dout4, valid4, last4, busy4;
    logic       ready8, dout8, valid8, last8, busy8;
    logic [7:0] rx8;

    int total = 0;
    int bad   = 0;

    bit q4[$];
    bit q8[$];
    bit armed = 1'b0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(ready4), .din(din4),
        .dout(dout4), .dout_valid(valid4), .dout_last(last4), .busy(busy4)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(ready8), .din(din8),
        .dout(dout8), .dout_valid(valid8), .dout_last(last8), .busy(busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: each accepted word becomes a queue of bits in wire order; one bit leaves per edge
    always @(posedge clk or negedge rst) begin
        bit acc4, acc8;
        if (!rst) begin
            q4.delete();
            q8.delete();
            armed = 1'b0;
        end else begin
            acc4 = lv4 && armed && (q4.size() <= 1);
            acc8 = lv8 && armed && (q8.size() <= 1);
            if (q4.size() > 0) void'(q4.pop_front());
            if (q8.size() > 0) void'(q8.pop_front());
            if (acc4) for (int i = 0; i < 4; i++) q4.push_back(din4[i]);
            if (acc8) for (int i = 7; i >= 0; i--) q8.push_back(din8[i]);
            armed = 1'b1;
        end
    end

    // An 8-bit MSB-first receiver fed by the 8-bit transmitter
    always @(posedge clk or negedge rst) begin
        if (!rst) rx8 <= 8'h00;
        else if (valid8) rx8 <= {rx8[6:0], dout8};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs packed as {dout, dout_valid, dout_last, busy, load_ready}
    always @(negedge clk) begin
        logic [4:0] e4, e8, a4, a8;
        e4 = {(q4.size() > 0) ? q4[0] : 1'b0, q4.size() > 0, q4.size() == 1, q4.size() > 0,
              rst && armed && (q4.size() <= 1)};
        e8 = {(q8.size() > 0) ? q8[0] : 1'b0, q8.size() > 0, q8.size() == 1, q8.size() > 0,
              rst && armed && (q8.size() <= 1)};
        a4 = {dout4, valid4, last4, busy4, ready4};
        a8 = {dout8, valid8, last8, busy8, ready8};
        checkOutput("model_w4", 32'(a4), 32'(e4));
        checkOutput("model_w8", 32'(a8), 32'(e8));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v4, input logic [3:0] d4, input logic v8, input logic [7:0] d8);
        lv4  = v4;
        din4 = d4;
        lv8  = v8;
        din8 = d8;
    endtask

    // Checks n stream cycles in order against literal bit and last patterns, one clock each
    task automatic expectBits(input string name, input int sel, input logic [31:0] bits,
                              input int n, input logic [31:0] lasts);
        logic [4:0] act, exp;
        for (int i = 0; i < n; i++) begin
            act = (sel != 0) ? {dout8, valid8, last8, busy8, ready8} : {dout4, valid4, last4, busy4, ready4};
            exp = {bits[i], 1'b1, lasts[i], 1'b1, lasts[i]};
            checkOutput($sformatf("%s[%0d]", name, i), 32'(act), 32'(exp));
            cyc();
        end
    endtask

    task automatic checkIdle4(input string name);
        checkOutput(name, 32'({dout4, valid4, last4, busy4, ready4}), 32'(5'b00001));
    endtask

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog: run did not complete, time %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);

        // Reset held with a word offered
        repeat (2) cyc();
        checkOutput("rst_outputs", 32'({dout4, valid4, last4, busy4, ready4}), 32'(0));
        rst = 1'b1;
        #2;
        checkOutput("ready_before_first_edge", 32'(ready4), 32'(0));
        cyc();
        checkOutput("ready_after_release", 32'(ready4), 32'(1));
        checkOutput("no_accept_after_release", 32'(busy4), 32'(0));
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        cyc();

        // Single word 1101, LSB first
        applyStimulus(1'b1, 4'hD, 1'b0, 8'h00);
        cyc();
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("single", 0, 32'b1101, 4, 32'b1000);
        checkIdle4("single_idle");

        // Back-to-back A then 3 with load_valid held high
        applyStimulus(1'b1, 4'hA, 1'b0, 8'h00);
        cyc();
        din4 = 4'h3;
        expectBits("b2b_a", 0, 32'b1010, 4, 32'b1000);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("b2b_b", 0, 32'b0011, 4, 32'b1000);
        checkIdle4("b2b_idle");

        // Load attempt while busy must be ignored
        applyStimulus(1'b1, 4'h9, 1'b0, 8'h00);
        cyc();
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("busy_b0", 0, 32'b1, 1, 32'b0);
        applyStimulus(1'b1, 4'h6, 1'b0, 8'h00);
        expectBits("busy_b1", 0, 32'b0, 1, 32'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("busy_b23", 0, 32'b10, 2, 32'b10);
        checkIdle4("busy_idle");

        // Reset in the middle of a word
        applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
        cyc();
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("abort", 0, 32'b11, 2, 32'b00);
        #1 rst = 1'b0;
        #1;
        checkOutput("midword_reset", 32'({dout4, valid4, last4, busy4, ready4}), 32'(0));
        cyc();
        rst = 1'b1;
        cyc();
        applyStimulus(1'b1, 4'h2, 1'b0, 8'h00);
        cyc();
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("after_abort", 0, 32'b0010, 4, 32'b1000);
        checkIdle4("after_abort_idle");

        // MSB-first 8-bit word C5 into the receiver
        applyStimulus(1'b0, 4'h0, 1'b1, 8'hC5);
        cyc();
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        expectBits("msb_c5", 1, 32'b10100011, 8, 32'b10000000);
        checkOutput("rx_c5", 32'(rx8), 32'h0000_00C5);

        // Random traffic on both instances with occasional resets
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 10) < 6, 4'($urandom), ($urandom % 10) < 6, 8'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
            cyc();
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
        repeat (12) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter: accepts a parallel word through a valid/ready handshake and drives it out one bit per clock on a single serial line, with bit-valid and end-of-word framing. It is the sending end for the team's serial shift-register chains and serial receivers. It supports gapless back-to-back words, so a downstream serial chain sees a continuous bitstream.

## Interface
- WIDTH, 4, bits per word; legal range 2 to 32.
- MSB_FIRST, 0, bit order. 0 sends din[0] first; 1 sends din[WIDTH-1] first.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream offers a word on din.
- load_ready  output  1  block can accept a word this cycle.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a valid bit this cycle.
- dout_last  output  1  dout carries the final bit of the current word.
- busy  output  1  a word is in transmission (state SHIFT).

## Operation
- Registers:
  - state: IDLE or SHIFT.
  - shreg: WIDTH bits.
  - cnt: $clog2(WIDTH) bits, counts bits already sent in the current word.
- Accept condition: load_valid && load_ready at a rising edge.
- load_ready:
  - Equals (state==IDLE) || (state==SHIFT && cnt==WIDTH-1).
  - Forced 0 while rst is low.
- IDLE:
  - dout, dout_valid, dout_last and busy are all 0.
  - On accept: shreg <= din, cnt <= 0, state <= SHIFT.
- SHIFT:
  - dout = shreg[0] when MSB_FIRST=0, else shreg[WIDTH-1].
  - dout_valid=1 and busy=1.
  - dout_last = (cnt==WIDTH-1).
- Each SHIFT edge that is not the last bit:
  - shreg shifts toward the output end: right when MSB_FIRST=0, left when MSB_FIRST=1.
  - The vacated bit is filled with 0.
  - cnt increments.
- Last-bit edge (cnt==WIDTH-1):
  - With accept: shreg <= din, cnt <= 0, state stays SHIFT. This gives a gapless reload with no idle cycle.
  - Without accept: state <= IDLE, cnt <= 0, shreg <= 0.
- load_valid during SHIFT with cnt < WIDTH-1:
  - Ignored, because load_ready=0.
  - Upstream must hold the word until it is accepted.
- din changes during SHIFT have no effect on the word in flight.
- dout, dout_valid, dout_last and busy are decoded from registers only, never combinationally from inputs. load_ready depends only on registers and rst.
- cnt never exceeds WIDTH-1. There is no wrap beyond the word boundary.

## Timing
- Reset values (rst low, applied asynchronously and immediately):
  - state=IDLE, shreg=0, cnt=0.
  - dout=0, dout_valid=0, dout_last=0, busy=0, load_ready=0.
- load_ready rises to 1 in the cycle after rst deasserts. A load cannot be accepted at the first edge after reset release. Benches synchronise rst release away from the clock edge.
- Latency for a word accepted at edge k:
  - First bit is valid in the cycle after edge k.
  - Last bit is valid in the cycle after edge k+WIDTH-1, with dout_last=1.
- Throughput: one word per WIDTH cycles when load_valid is held high; dout_valid stays continuously 1.
- Reset mid-word: the word is discarded and all outputs drop to reset values at once. After release the block restarts in IDLE.
- Simultaneous last bit and accept: the last bit of the old word is valid in that cycle. The first bit of the new word is valid in the next cycle.

## Test plan
- Reset: hold rst low for 2 cycles with load_valid=1 and din=4'hF.
  - Required: all outputs 0 and no word accepted.
  - After release, load_ready=1 from the next cycle.
- Single word, WIDTH=4, MSB_FIRST=0, din=4'b1101 accepted at edge k:
  - dout = 1,0,1,1 in cycles k+1..k+4.
  - dout_valid=1 for exactly those 4 cycles.
  - dout_last=1 only in cycle k+4.
  - busy=0 from cycle k+5.
- Back-to-back: din=4'hA, then 4'h3 offered with load_valid held high.
  - dout = 0,1,0,1,1,1,0,0.
  - dout_valid=1 for 8 consecutive cycles.
  - dout_last high in cycles 4 and 8.
  - load_ready high only in IDLE and in cycles 4 and 8.
- Load while busy: during word 4'h9, pulse load_valid with din=4'h6 at bit 1.
  - Required: the pulse is not accepted and the stream is 1,0,0,1 only.
  - Afterwards IDLE with load_ready=1.
- Reset mid-word: assert rst after 2 bits of 4'hF, release, then send 4'h2.
  - Required: outputs 0 immediately on reset.
  - Then the stream 0,1,0,0 with no residue from the aborted word.
- MSB_FIRST=1, WIDTH=8, din=8'hC5:
  - dout = 1,1,0,0,0,1,0,1.
  - dout_last on the 8th bit.
  - Looped into an 8-bit serial receiver, it reconstructs 8'hC5.
